// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per clock.
// Three-state FSM (IDLE, SHIFT, DONE); result and flags update together on
// the final SHIFT edge and are held until the next operation completes.
// Optional feature: define SERIAL_SUB_ADD_MODE_EN to add the 'op' port
// (0 = subtract, 1 = add; borrow then reports carry-out).
module serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_borrow;
    logic             r_zero;
    logic             r_ovf;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             r_op;
`endif

    logic             w_op;
    logic             w_ai;
    logic             w_bi;
    logic             w_bit;
    logic             w_c_next;
    logic             w_last;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

`ifdef SERIAL_SUB_ADD_MODE_EN
    assign w_op = r_op;
`else
    assign w_op = 1'b0;
`endif

    assign w_ai   = r_a_sh[0];
    assign w_bi   = r_b_sh[0];
    assign w_last = (r_cnt == CW'(WIDTH - 1));
    assign w_res  = {w_bit, r_acc[WIDTH-1:1]};

    // One-bit serial ALU slice plus final-result overflow evaluation
    always_comb begin
        w_bit    = w_ai ^ w_bi ^ r_c;
        w_c_next = 1'b0;
        w_ovf    = 1'b0;
        if (w_op) begin
            w_c_next = (w_ai & w_bi) | (r_c & (w_ai ^ w_bi));
            w_ovf    = (r_a_msb == r_b_msb) && (w_bit != r_a_msb);
        end else begin
            w_c_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_c);
            w_ovf    = (r_a_msb != r_b_msb) && (w_bit != r_a_msb);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? SHIFT : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, serial shifting and end-of-operation result update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            r_op     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
                        r_c     <= 1'b0;
                        r_cnt   <= '0;
                        r_acc   <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                        r_op    <= op;
`endif
                    end
                end
                SHIFT: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_c    <= w_c_next;
                    r_acc  <= w_res;
                    if (w_last) begin
                        // counter returns to 0 instead of wrapping past WIDTH-1
                        r_cnt    <= '0;
                        r_result <= w_res;
                        r_borrow <= w_c_next;
                        r_zero   <= (w_res == '0);
                        r_ovf    <= w_ovf;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == SHIFT);
    assign done     = (r_state == DONE);
    assign result   = r_result;
    assign borrow   = r_borrow;
    assign zero     = r_zero;
    assign overflow = r_ovf;

endmodule
